// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default PROT, slave FSM
// encoding and the peripheral access record.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_WR_RESP,
    ST_RD_RESP
  } slv_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } per_acc_t;

endpackage

// File: rtl/axi4_lite_chan_buf.sv
// Single-entry valid/ready holding register; ready is registered and is the
// inverse of the next-cycle full flag.
module axi4_lite_chan_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         consume,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_q, full_d;
  logic         ready_q, ready_d;
  logic [W-1:0] data_q, data_d;
  logic         hs;

  always_comb begin
    hs      = in_valid & ready_q;
    full_d  = full_q;
    data_d  = data_q;
    if (consume) full_d = 1'b0;
    if (hs) begin
      full_d = 1'b1;
      data_d = in_data;
    end
    // Ready is held low through reset and rises on the first edge after.
    ready_d = ~full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign in_ready = ready_q;
  assign full     = full_q;
  assign data     = data_q;

endmodule

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite responder: buffers AW/W/AR, issues one request/ready access at a
// time to the peripheral bus, with an optional hung-peripheral timeout.
module axi4_lite_slave_if
  import axi4_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        per_req,
  output logic        per_wr,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wstrb,
  input  logic [31:0] per_rdata,
  input  logic        per_ready,
  input  logic        per_error
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic        unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  logic        aw_full, w_full, ar_full;
  logic [31:0] aw_addr, ar_addr;
  logic [35:0] w_data;
  logic        wr_consume, rd_consume;

  axi4_lite_chan_buf #(.W(32)) u_aw_buf (
    .clk(clk), .rst_n(rst_n),
    .in_valid(S_AXI_AWVALID), .in_data(S_AXI_AWADDR), .in_ready(S_AXI_AWREADY),
    .consume(wr_consume), .full(aw_full), .data(aw_addr)
  );

  axi4_lite_chan_buf #(.W(36)) u_w_buf (
    .clk(clk), .rst_n(rst_n),
    .in_valid(S_AXI_WVALID), .in_data({S_AXI_WSTRB, S_AXI_WDATA}), .in_ready(S_AXI_WREADY),
    .consume(wr_consume), .full(w_full), .data(w_data)
  );

  axi4_lite_chan_buf #(.W(32)) u_ar_buf (
    .clk(clk), .rst_n(rst_n),
    .in_valid(S_AXI_ARVALID), .in_data(S_AXI_ARADDR), .in_ready(S_AXI_ARREADY),
    .consume(rd_consume), .full(ar_full), .data(ar_addr)
  );

  slv_state_e  state_q, state_d;
  per_acc_t    acc_q, acc_d;
  logic        per_req_q, per_req_d;
  logic        last_wr_q, last_wr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_elig, rd_elig, timeout, done;
  logic [1:0]  done_resp;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    per_req_d  = per_req_q;
    last_wr_d  = last_wr_q;
    cnt_d      = cnt_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    wr_consume = 1'b0;
    rd_consume = 1'b0;
    wr_elig    = aw_full & w_full;
    rd_elig    = ar_full;
    // Timeout fires on the edge that would complete the TIMEOUT_CYCLES-th wait.
    timeout    = (TIMEOUT_CYCLES != 0) && per_req_q && !per_ready && (cnt_q == TMO_LAST);
    done       = per_ready | timeout;
    done_resp  = (per_ready && !per_error) ? RESP_OKAY : RESP_SLVERR;

    case (state_q)
      ST_IDLE: begin
        if (wr_elig && (!rd_elig || !last_wr_q)) begin
          state_d   = ST_WR_REQ;
          per_req_d = 1'b1;
          acc_d     = '{wr: 1'b1, addr: aw_addr, wdata: w_data[31:0], wstrb: w_data[35:32]};
          last_wr_d = 1'b1;
          cnt_d     = '0;
        end else if (rd_elig) begin
          state_d   = ST_RD_REQ;
          per_req_d = 1'b1;
          acc_d     = '{wr: 1'b0, addr: ar_addr, wdata: 32'h0, wstrb: 4'h0};
          last_wr_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_WR_REQ: begin
        if (done) begin
          state_d    = ST_WR_RESP;
          per_req_d  = 1'b0;
          acc_d.wr   = 1'b0;
          wr_consume = 1'b1;
          bvalid_d   = 1'b1;
          bresp_d    = done_resp;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RD_REQ: begin
        if (done) begin
          state_d    = ST_RD_RESP;
          per_req_d  = 1'b0;
          rd_consume = 1'b1;
          rvalid_d   = 1'b1;
          rresp_d    = done_resp;
          rdata_d    = per_ready ? per_rdata : 32'h0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WR_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      per_req_q <= 1'b0;
      last_wr_q <= 1'b0;
      cnt_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      per_req_q <= per_req_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign per_req      = per_req_q;
  assign per_wr       = acc_q.wr;
  assign per_addr     = acc_q.addr;
  assign per_wdata    = acc_q.wdata;
  assign per_wstrb    = acc_q.wstrb;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slave_if.sv
// Directed bench for axi4_lite_slave_if: vector table of single accesses plus
// hand sequences for early W, held RREADY, arbitration and mid-access reset.
module tb_axi4_lite_slave_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        per_req, per_wr;
  logic [31:0] per_addr, per_wdata;
  logic [3:0]  per_wstrb;
  logic [31:0] per_rdata;
  logic        per_ready = 1'b0;
  logic        per_error;

  axi4_lite_slave_if #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .per_req(per_req), .per_wr(per_wr), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_wstrb(per_wstrb),
    .per_rdata(per_rdata), .per_ready(per_ready), .per_error(per_error)
  );

  always #5 clk = ~clk;

  // Peripheral model: ready after p_wait cycles of per_req, or never if hung.
  int          p_wait = 0;
  bit          p_hang = 1'b0;
  logic [31:0] p_rdata = '0;
  logic        p_err = 1'b0;
  int          p_cnt = 0;
  int          req_len = 0;
  logic [68:0] acc_q[$];

  assign per_rdata = p_rdata;
  assign per_error = p_err;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (per_req) begin
        if (p_cnt == 0) begin
          acc_q.push_back({per_wr, per_addr, per_wdata, per_wstrb});
          req_len = 0;
        end
        req_len++;
        per_ready = !p_hang && (p_cnt == p_wait);
        p_cnt++;
      end else begin
        per_ready = 1'b0;
        p_cnt = 0;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Drive the selected channels (fields preset by caller) until each handshakes.
  task automatic send(input bit do_aw, input bit do_w, input bit do_ar);
    bit aw_d, w_d, ar_d, hs_aw, hs_w, hs_ar;
    int n;
    aw_d = !do_aw; w_d = !do_w; ar_d = !do_ar;
    S_AXI_AWVALID = do_aw; S_AXI_WVALID = do_w; S_AXI_ARVALID = do_ar;
    n = 0;
    while (!(aw_d && w_d && ar_d) && n < 20) begin
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      hs_ar = S_AXI_ARVALID && S_AXI_ARREADY;
      cyc(); n++;
      if (hs_aw) begin S_AXI_AWVALID = 1'b0; aw_d = 1'b1; end
      if (hs_w)  begin S_AXI_WVALID = 1'b0;  w_d = 1'b1;  end
      if (hs_ar) begin S_AXI_ARVALID = 1'b0; ar_d = 1'b1; end
    end
    if (n >= 20) chk("handshake_budget", 72'(n), 72'd0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
  endtask

  // Wait for B or R valid; lat counts edges from the last address/data handshake.
  task automatic wait_resp(input bit wr, output int lat);
    lat = 0;
    while (!(wr ? S_AXI_BVALID : S_AXI_RVALID) && lat < 40) begin
      cyc(); lat++;
    end
  endtask

  task automatic run_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic [31:0] rdata, output int lat);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    if (wr) begin
      S_AXI_AWADDR = addr; S_AXI_WDATA = wdata; S_AXI_WSTRB = strb;
      send(1'b1, 1'b1, 1'b0);
    end else begin
      S_AXI_ARADDR = addr;
      send(1'b0, 1'b0, 1'b1);
    end
    wait_resp(wr, lat);
    resp  = wr ? S_AXI_BRESP : S_AXI_RRESP;
    rdata = S_AXI_RDATA;
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_c;
    bit          hang;
    logic [31:0] prdata;
    logic        perr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_len;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    logic [68:0] rec;
    logic [3:0]  ord;
    int          extra;

    vecs[0] = '{1'b1, 32'h0000_1000, 32'hCAFE_BABE, 4'hF, 0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 2, 1};
    vecs[1] = '{1'b1, 32'h0000_1004, 32'h55AA_00FF, 4'h0, 2, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 4, 3};
    vecs[2] = '{1'b1, 32'h0000_1008, 32'h0102_0304, 4'h5, 1, 1'b0, 32'h0, 1'b1, 2'b10, 32'h0, 3, 2};
    vecs[3] = '{1'b0, 32'h0000_2004, 32'h0, 4'h0, 5, 1'b0, 32'h1234_5678, 1'b1, 2'b10, 32'h1234_5678, 7, 6};
    vecs[4] = '{1'b0, 32'h0000_2000, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5_5A5A, 1'b0, 2'b00, 32'hA5A5_5A5A, 2, 1};
    vecs[5] = '{1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_DEAD, 1'b0, 2'b10, 32'h0, 9, 8};
    vecs[6] = '{1'b0, 32'h0000_3004, 32'h0, 4'h0, 7, 1'b0, 32'h0BAD_F00D, 1'b0, 2'b00, 32'h0BAD_F00D, 9, 8};
    vecs[7] = '{1'b1, 32'h0000_300C, 32'h7777_8888, 4'h3, 0, 1'b1, 32'h0, 1'b0, 2'b10, 32'h0, 9, 8};
    vecs[8] = '{1'b0, 32'h0000_2008, 32'h0, 4'h0, 0, 1'b0, 32'h1111_2222, 1'b0, 2'b00, 32'h1111_2222, 2, 1};

    // Reset values, then READY rising one edge after release.
    #3;
    chk("reset_ctrl", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                       S_AXI_RVALID, per_req, per_wr}, 72'd0);
    chk("reset_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, per_wstrb, per_addr}, 72'd0);
    chk("reset_wdata", per_wdata, 72'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("ready_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 72'd0);
    cyc();
    chk("ready_after_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 72'h7);

    for (int i = 0; i < 9; i++) begin
      p_wait = vecs[i].wait_c; p_hang = vecs[i].hang;
      p_rdata = vecs[i].prdata; p_err = vecs[i].perr;
      acc_q.delete();
      run_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp, rdata, lat);
      chk($sformatf("v%0d_resp", i), resp, vecs[i].exp_resp);
      chk($sformatf("v%0d_lat", i), 72'(lat), 72'(vecs[i].exp_lat));
      chk($sformatf("v%0d_req_len", i), 72'(req_len), 72'(vecs[i].exp_len));
      chk($sformatf("v%0d_n_acc", i), 72'(acc_q.size()), 72'd1);
      rec = (acc_q.size() > 0) ? acc_q[0] : 69'h0;
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_wr_fields", i), rec, {1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].strb});
      end else begin
        chk($sformatf("v%0d_rd_fields", i), rec[68:36], {1'b0, vecs[i].addr});
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      end
      chk($sformatf("v%0d_idle", i), {S_AXI_BVALID, S_AXI_RVALID, per_req}, 72'd0);
    end
    p_hang = 1'b0; p_wait = 0; p_err = 1'b0;

    // W arrives 3 cycles before AW.
    acc_q.delete();
    S_AXI_BREADY = 1'b1;
    S_AXI_WDATA = 32'hFEED_0001; S_AXI_WSTRB = 4'hC;
    send(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("early_w_wready_%0d", k), S_AXI_WREADY, 72'd0);
      cyc();
    end
    chk("early_w_no_acc", 72'(acc_q.size()), 72'd0);
    S_AXI_AWADDR = 32'h0000_1010;
    send(1'b1, 1'b0, 1'b0);
    wait_resp(1'b1, lat);
    chk("early_w_lat", 72'(lat), 72'd2);
    chk("early_w_bresp", S_AXI_BRESP, 72'd0);
    cyc();
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      if (S_AXI_BVALID) extra++;
      cyc();
    end
    chk("early_w_single_b", 72'(extra), 72'd0);
    chk("early_w_n_acc", 72'(acc_q.size()), 72'd1);
    rec = (acc_q.size() > 0) ? acc_q[0] : 69'h0;
    chk("early_w_fields", rec, {1'b1, 32'h0000_1010, 32'hFEED_0001, 4'hC});
    chk("early_w_wready_back", S_AXI_WREADY, 72'd1);

    // Read with RREADY held low: response must stay put.
    p_wait = 5; p_err = 1'b1; p_rdata = 32'h1234_5678;
    S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 32'h0000_2004;
    send(1'b0, 1'b0, 1'b1);
    wait_resp(1'b0, lat);
    chk("hold_lat", 72'(lat), 72'd7);
    p_rdata = 32'h0; p_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("hold_r_%0d", k), {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, 2'b10, 32'h1234_5678});
    end
    S_AXI_RREADY = 1'b1;
    cyc();
    chk("hold_release", S_AXI_RVALID, 72'd0);
    p_wait = 0;

    // Arbitration from reset: write first, then alternate.
    do_reset();
    acc_q.delete();
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    S_AXI_AWADDR = 32'h0000_4000; S_AXI_WDATA = 32'h4444_0000; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 32'h0000_5000;
    send(1'b1, 1'b1, 1'b1);
    repeat (8) cyc();
    send(1'b1, 1'b1, 1'b1);
    repeat (8) cyc();
    chk("arb_n_acc", 72'(acc_q.size()), 72'd4);
    ord = 4'hx;
    if (acc_q.size() == 4) ord = {acc_q[0][68], acc_q[1][68], acc_q[2][68], acc_q[3][68]};
    chk("arb_order", ord, 72'hA);

    // Reset during WR_REQ with an AR already buffered.
    p_hang = 1'b1;
    S_AXI_AWADDR = 32'h0000_6000; S_AXI_WDATA = 32'h6666_6666;
    send(1'b1, 1'b1, 1'b0);
    cyc();
    chk("mid_rst_req_before", per_req, 72'd1);
    S_AXI_ARADDR = 32'h0000_7000;
    send(1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {per_req, per_wr, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                            S_AXI_BVALID, S_AXI_RVALID}, 72'd0);
    chk("mid_rst_addr", per_addr, 72'd0);
    cyc();
    rst_n = 1'b1;
    p_hang = 1'b0;
    acc_q.delete();
    cyc();
    chk("mid_rst_ready_back", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 72'h7);
    repeat (3) cyc();
    chk("mid_rst_discard", 72'(acc_q.size()), 72'd0);
    run_access(1'b1, 32'h0000_1020, 32'h0BAD_BEEF, 4'hF, resp, rdata, lat);
    chk("post_rst_resp", resp, 72'd0);
    chk("post_rst_lat", 72'(lat), 72'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
